// File: rtl/switch_request_arbiter.sv
// Round-robin arbiter sharing one resource between n requesters.
// The grant is one-hot, a hold is limited to a quantum while others wait, and a dead-time guard separates grants.
module switch_request_arbiter #(
    parameter int n       = 4,
    parameter int quantum = 16,
    parameter int guard   = 2,
    localparam int IDW    = (n > 1) ? $clog2(n) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [n-1:0]   req,
    output logic [n-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           preempt
);

    localparam int HCW = (quantum > 1) ? $clog2(quantum) : 1;
    localparam int GCW = (guard > 1) ? $clog2(guard) : 1;
    localparam logic [HCW-1:0] HOLD_LAST  = HCW'(quantum - 1);
    localparam logic [GCW-1:0] GUARD_LAST = GCW'(guard - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt, pick, gnt_id_nxt;
    logic [HCW-1:0] hold_cnt, hold_nxt;
    logic [GCW-1:0] guard_cnt, guard_nxt;
    logic [n-1:0]   gnt_nxt;
    logic           preempt_nxt;
    logic           any_req, holder_req, others_req, hold_last, guard_last, start;

    // Nearest requester at or after the pointer, measured as wrap-around distance.
    function automatic logic [IDW-1:0] arb_pick(input logic [n-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] best;
        int             best_d;
        int             d;
        best   = '0;
        best_d = n;
        for (int i = 0; i < n; i++) begin
            d = (i + n - int'(p)) % n;
            if (r[i] && d < best_d) begin
                best_d = d;
                best   = IDW'(i);
            end
        end
        return best;
    endfunction

    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] idx);
        if (int'(idx) >= n - 1) return '0;
        return idx + IDW'(1);
    endfunction

    assign any_req    = |req;
    assign holder_req = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign hold_last  = (hold_cnt == HOLD_LAST);
    assign guard_last = (guard_cnt == GUARD_LAST);
    assign pick       = arb_pick(req, ptr);
    assign start      = any_req && (state == IDLE || (state == GUARD && guard_last));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (!holder_req || (hold_last && others_req)) state_nxt = GUARD;
            GUARD:   if (guard_last) state_nxt = any_req ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Release is tested before preemption so a dropping holder never produces a preempt pulse.
    always_comb begin
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        ptr_nxt     = ptr;
        preempt_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        guard_nxt   = guard_cnt;
        if (start) begin
            gnt_nxt    = n'(1) << pick;
            gnt_id_nxt = pick;
            ptr_nxt    = ptr_after(pick);
            hold_nxt   = '0;
            guard_nxt  = '0;
        end else if (state == GRANT) begin
            if (!holder_req) begin
                gnt_nxt   = '0;
                guard_nxt = '0;
            end else if (hold_last && others_req) begin
                gnt_nxt     = '0;
                preempt_nxt = 1'b1;
                guard_nxt   = '0;
            end else if (!hold_last) begin
                hold_nxt = hold_cnt + HCW'(1);
            end
        end else if (state == GUARD) begin
            guard_nxt = guard_last ? '0 : guard_cnt + GCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            preempt   <= preempt_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            guard_cnt <= guard_nxt;
        end
    end

endmodule

// File: tb/tb_switch_request_arbiter.sv
// Directed bench for switch_request_arbiter with n=4, quantum=16, guard=2.
module tb_switch_request_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       preempt;

    int checks;
    int errors;

    switch_request_arbiter #(.n(4), .quantum(16), .guard(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After tick the outputs show the current cycle and req set now is that cycle's input.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b vld=%b id=%0d pre=%b required 0000 0 0 0", gnt, gnt_valid, gnt_id, preempt);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_grant: got gnt=%b vld=%b required 0000 0", gnt, gnt_valid);
        end
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL single_grant c%0d: got gnt=%b id=%0d vld=%b pre=%b required 0100 2 1 0", c, gnt, gnt_id, gnt_valid, preempt);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_id !== 2'd2) begin
                errors++;
                $display("FAIL single_release c%0d: got gnt=%b vld=%b pre=%b id=%0d required 0000 0 0 2", c, gnt, gnt_valid, preempt, gnt_id);
            end
        end
    endtask

    task automatic test_all_requesting();
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            for (int c = 0; c < 16; c++) begin
                checks++;
                if (gnt !== exp_gnt || gnt_id !== 2'(k % 4) || preempt !== 1'b0) begin
                    errors++;
                    $display("FAIL rotate_hold k%0d c%0d: got gnt=%b id=%0d pre=%b required %b %0d 0", k, c, gnt, gnt_id, preempt, exp_gnt, k % 4);
                end
                tick();
            end
            if (k < 4) begin
                checks++;
                if (gnt !== 4'b0000 || preempt !== 1'b1) begin
                    errors++;
                    $display("FAIL rotate_gap1 k%0d: got gnt=%b pre=%b required 0000 1", k, gnt, preempt);
                end
                tick();
                checks++;
                if (gnt !== 4'b0000 || preempt !== 1'b0) begin
                    errors++;
                    $display("FAIL rotate_gap2 k%0d: got gnt=%b pre=%b required 0000 0", k, gnt, preempt);
                end
                tick();
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_preemption();
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (gnt !== 4'b0001 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL preempt_hold c%0d: got gnt=%b id=%0d pre=%b required 0001 0 0", c, gnt, gnt_id, preempt);
            end
            if (c == 5) req = 4'b1001;
            tick();
        end
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b1) begin
            errors++;
            $display("FAIL preempt_pulse: got gnt=%b vld=%b pre=%b required 0000 0 1", gnt, gnt_valid, preempt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL preempt_guard: got gnt=%b pre=%b required 0000 0", gnt, preempt);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL preempt_next: got gnt=%b id=%0d vld=%b pre=%b required 1000 3 1 0", gnt, gnt_id, gnt_valid, preempt);
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_release_with_waiter();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
                errors++;
                $display("FAIL release_hold c%0d: got gnt=%b id=%0d required 0010 1", c, gnt, gnt_id);
            end
            tick();
        end
        req = 4'b0001;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL release_gap t+%0d: got gnt=%b vld=%b pre=%b required 0000 0 0", c, gnt, gnt_valid, preempt);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL release_next: got gnt=%b id=%0d vld=%b pre=%b required 0001 0 1 0", gnt, gnt_id, gnt_valid, preempt);
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_lone_holder();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 100; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL lone_hold c%0d: got gnt=%b vld=%b pre=%b required 0010 1 0", c, gnt, gnt_valid, preempt);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL midrst_pre_grant: got gnt=%b id=%0d required 0100 2", gnt, gnt_id);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_grant_out: got gnt=%b vld=%b id=%0d pre=%b required 0000 0 0 0", gnt, gnt_valid, gnt_id, preempt);
        end
        reset = 1'b0;
        req   = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant_next: got gnt=%b id=%0d vld=%b required 0001 0 1", gnt, gnt_id, gnt_valid);
        end
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_guard: got gnt=%b pre=%b required 0000 0", gnt, preempt);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_guard_out: got gnt=%b vld=%b id=%0d pre=%b required 0000 0 0 0", gnt, gnt_valid, gnt_id, preempt);
        end
        reset = 1'b0;
        req   = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_guard_next: got gnt=%b id=%0d vld=%b required 0001 0 1", gnt, gnt_id, gnt_valid);
        end
        req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        test_reset();
        test_single();
        test_all_requesting();
        test_preemption();
        test_release_with_waiter();
        test_lone_holder();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
